// File: rtl/lif_integrate_fire.sv
// Leaky integrate-and-fire neuron: per-step leak, input integration, threshold spike, refractory.
// Define SPIKE_COUNT_EN to add a saturating 16-bit spike_count output.
module lif_integrate_fire #(
  parameter int unsigned n_stage  = 10,
  parameter int unsigned REFRAC_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [n_stage+1:0]  current_in,
  input  logic                current_valid,
  input  logic [2:0]          shift,
  input  logic [n_stage+1:0]  threshold,
  input  logic [REFRAC_W-1:0] refrac_cycles,
  output logic                spike,
  output logic [n_stage+1:0]  u_out,
  output logic [1:0]          state_out
`ifdef SPIKE_COUNT_EN
  ,
  output logic [15:0]         spike_count
`endif
);

  localparam int unsigned UW = n_stage + 2;

  localparam logic [1:0] StIntegrate = 2'b00;
  localparam logic [1:0] StFire      = 2'b01;
  localparam logic [1:0] StRefrac    = 2'b10;

  localparam logic [REFRAC_W-1:0] CntOne = REFRAC_W'(1);

  logic [UW-1:0]       u_q, u_d;
  logic [1:0]          state_q, state_d;
  logic [REFRAC_W-1:0] cnt_q, cnt_d;
  logic                spike_q, spike_d;

  logic [UW-1:0] leak;
  logic [UW-1:0] u_leaked;
  logic [UW-1:0] cur;
  logic [UW:0]   sum;
  logic [UW-1:0] u_step;
  logic          fire_hit;
  logic          fire_now;

  // u - (u >> k) can never go negative, so only the addition needs a carry bit.
  always_comb begin
    leak     = (shift == 3'd0) ? '0 : (u_q >> shift);
    u_leaked = u_q - leak;
    cur      = current_valid ? current_in : '0;
    sum      = {1'b0, u_leaked} + {1'b0, cur};
    u_step   = sum[UW] ? '1 : sum[UW-1:0];
    fire_hit = (threshold != '0) && (u_step >= threshold);
    fire_now = (state_q == StIntegrate) && en && fire_hit;
  end

  always_comb begin
    u_d     = u_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    case (state_q)
      StIntegrate: begin
        if (en) begin
          if (fire_hit) begin
            u_d     = '0;
            state_d = StFire;
            spike_d = 1'b1;
          end else begin
            u_d = u_step;
          end
        end
      end
      StFire: begin
        u_d     = '0;
        cnt_d   = refrac_cycles;
        state_d = (refrac_cycles != '0) ? StRefrac : StIntegrate;
      end
      StRefrac: begin
        u_d = '0;
        if (en) begin
          if (cnt_q <= CntOne) begin
            cnt_d   = '0;
            state_d = StIntegrate;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
      default: begin
        u_d     = '0;
        cnt_d   = '0;
        state_d = StIntegrate;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_q     <= '0;
      state_q <= StIntegrate;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      u_q     <= u_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign spike     = spike_q;
  assign u_out     = u_q;
  assign state_out = state_q;

`ifdef SPIKE_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (fire_now && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign spike_count = count_q;
`else
  logic unused_fire_now;
  assign unused_fire_now = fire_now;
`endif

endmodule

// File: tb/tb_lif_integrate_fire.sv
// Directed bench for lif_integrate_fire; define SPIKE_COUNT_EN to also exercise spike_count.
module tb_lif_integrate_fire;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] current_in;
  logic        current_valid;
  logic [2:0]  shift;
  logic [11:0] threshold;
  logic [3:0]  refrac_cycles;
  logic        spike;
  logic [11:0] u_out;
  logic [1:0]  state_out;
`ifdef SPIKE_COUNT_EN
  logic [15:0] spike_count;
`endif

  int tests_run;
  int tests_failed;

  lif_integrate_fire #(
    .n_stage  (10),
    .REFRAC_W (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .current_in    (current_in),
    .current_valid (current_valid),
    .shift         (shift),
    .threshold     (threshold),
    .refrac_cycles (refrac_cycles),
    .spike         (spike),
    .u_out         (u_out),
    .state_out     (state_out)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count   (spike_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle past it before the caller samples.
  task automatic step(input logic e, input logic [11:0] cur, input logic v);
    en            = e;
    current_in    = cur;
    current_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int leak_exp [9] = '{100, 50, 25, 13, 7, 4, 2, 1, 1};

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    en            = 1'b0;
    current_in    = '0;
    current_valid = 1'b0;
    shift         = 3'd0;
    threshold     = '0;
    refrac_cycles = '0;

    // Reset state
    do_reset();
    check("rst_u", u_out, 0);
    check("rst_spike", spike, 0);
    check("rst_state", state_out, 0);

    // Integrate to fire
    threshold = 12'd100;
    step(1, 12'd30, 1); check("int_u1", u_out, 30);  check("int_sp1", spike, 0);
    step(1, 12'd30, 1); check("int_u2", u_out, 60);
    step(1, 12'd30, 1); check("int_u3", u_out, 90);  check("int_sp3", spike, 0);
    step(1, 12'd30, 1); check("fire_u", u_out, 0);   check("fire_sp", spike, 1);
    check("fire_state", state_out, 1);
    step(0, 12'd30, 1); check("post_sp", spike, 0);  check("post_state", state_out, 0);
    check("post_u", u_out, 0);
    step(1, 12'd30, 1); check("reint_u", u_out, 30);
    step(0, 12'd30, 1); check("hold_u", u_out, 30);  check("hold_sp", spike, 0);

    // Leak only
    do_reset();
    threshold = 12'd0;
    shift     = 3'd0;
    step(1, 12'd200, 1); check("leak_u0", u_out, 200);
    shift = 3'd1;
    for (int i = 0; i < 9; i++) begin
      step(1, 12'd0, 0);
      check($sformatf("leak_u%0d", i + 1), u_out, leak_exp[i]);
    end

    // Saturation, then a threshold of all-ones reached only by saturating
    do_reset();
    shift     = 3'd0;
    threshold = 12'd0;
    step(1, 12'd4095, 1); check("sat_u1", u_out, 4095); check("sat_sp1", spike, 0);
    step(1, 12'd4095, 1); check("sat_u2", u_out, 4095); check("sat_sp2", spike, 0);
    threshold = 12'd4095;
    step(1, 12'd1, 1); check("satfire_sp", spike, 1); check("satfire_u", u_out, 0);

    // Refractory with a frozen step in the middle
    do_reset();
    threshold     = 12'd10;
    refrac_cycles = 4'd3;
    step(1, 12'd20, 1); check("rf_sp", spike, 1);       check("rf_st0", state_out, 1);
    step(1, 12'd20, 1); check("rf_st1", state_out, 2);  check("rf_u1", u_out, 0);
    check("rf_sp1", spike, 0);
    step(1, 12'd20, 1); check("rf_st2", state_out, 2);  check("rf_u2", u_out, 0);
    step(0, 12'd20, 1); check("rf_frz", state_out, 2);
    step(1, 12'd20, 1); check("rf_st3", state_out, 2);  check("rf_u3", u_out, 0);
    step(1, 12'd20, 1); check("rf_st4", state_out, 0);  check("rf_u4", u_out, 0);
    threshold = 12'd100;
    step(1, 12'd20, 1); check("rf_u5", u_out, 20);      check("rf_sp5", spike, 0);

    // Reset mid-refractory (counter at 2)
    do_reset();
    threshold     = 12'd10;
    refrac_cycles = 4'd3;
    step(1, 12'd20, 1);
    step(1, 12'd20, 1);
    step(1, 12'd20, 1); check("mr_pre", state_out, 2);
    rst = 1'b1;
    step(1, 12'd20, 1);
    rst = 1'b0;
    check("mr_u", u_out, 0); check("mr_state", state_out, 0); check("mr_sp", spike, 0);
    threshold = 12'd100;
    step(1, 12'd5, 1); check("mr_int", u_out, 5);

`ifdef SPIKE_COUNT_EN
    do_reset();
    check("cnt_rst0", spike_count, 0);
    threshold     = 12'd10;
    refrac_cycles = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step(1, 12'd20, 1);
      step(0, 12'd0, 0);
    end
    check("cnt_5", spike_count, 5);
    do_reset();
    check("cnt_clr", spike_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
